// File: rtl/flex_counter_bank_if.sv
// Control and status bundle for flex_counter_bank.
// Every control bit is a level sampled on each rising clock edge; there is no valid/ready handshake.
interface flex_counter_bank_if #(
   parameter int NUM_CH       = 4,
   parameter int NUM_CNT_BITS = 8
);
   logic [NUM_CH-1:0]              clear;
   logic [NUM_CH-1:0]              count_enable;
   logic [NUM_CH-1:0]              count_down;
   logic [NUM_CH-1:0]              sat_mode;
   logic [NUM_CH-1:0]              save_count;
   logic [NUM_CH-1:0]              revert_count;
   logic [NUM_CH*NUM_CNT_BITS-1:0] rollover_val;
   logic [NUM_CH*NUM_CNT_BITS-1:0] count_out;
   logic [NUM_CH-1:0]              rollover_flag;
   logic [NUM_CH-1:0]              wrap_pulse;
   logic [NUM_CH-1:0]              save_full;
   logic [NUM_CH-1:0]              save_empty;
   logic [NUM_CH-1:0]              revert_err;

   modport master (
      output clear, count_enable, count_down, sat_mode, save_count, revert_count, rollover_val,
      input  count_out, rollover_flag, wrap_pulse, save_full, save_empty, revert_err
   );

   modport slave (
      input  clear, count_enable, count_down, sat_mode, save_count, revert_count, rollover_val,
      output count_out, rollover_flag, wrap_pulse, save_full, save_empty, revert_err
   );
endinterface

// File: rtl/flex_counter_bank.sv
// Bank of independent up/down wrap/saturate counters, each with a small LIFO of
// saved counts for nested rollback. All outputs are registered.
module flex_counter_bank #(
   parameter int NUM_CH       = 4,
   parameter int NUM_CNT_BITS = 8,
   parameter int SAVE_DEPTH   = 2
) (
   input  logic                clk,
   input  logic                rst,
   flex_counter_bank_if.slave  bus
);
   localparam int DW = $clog2(SAVE_DEPTH + 1);

   typedef logic [NUM_CNT_BITS-1:0] cnt_t;

   cnt_t              cnt_q  [NUM_CH];
   cnt_t              cnt_d  [NUM_CH];
   cnt_t              lifo_q [NUM_CH][SAVE_DEPTH];
   cnt_t              lifo_d [NUM_CH][SAVE_DEPTH];
   logic [DW-1:0]     depth_q [NUM_CH];
   logic [DW-1:0]     depth_d [NUM_CH];
   logic [NUM_CH-1:0] flag_q, flag_d;
   logic [NUM_CH-1:0] wrap_q, wrap_d;
   logic [NUM_CH-1:0] full_q, full_d;
   logic [NUM_CH-1:0] empty_q, empty_d;
   logic [NUM_CH-1:0] err_q, err_d;

   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         cnt_t rval;
         logic do_rev;
         logic do_save;
         rval       = bus.rollover_val[c*NUM_CNT_BITS +: NUM_CNT_BITS];
         cnt_d[c]   = cnt_q[c];
         lifo_d[c]  = lifo_q[c];
         depth_d[c] = depth_q[c];
         wrap_d[c]  = 1'b0;
         err_d[c]   = err_q[c];
         // A revert cancelled by clear has no effect at all, so it does not suppress a save.
         do_rev  = bus.revert_count[c] & ~bus.clear[c];
         do_save = bus.save_count[c] & ~do_rev;

         if (do_save) begin
            if (depth_q[c] == DW'(SAVE_DEPTH)) begin
               err_d[c] = 1'b1;
            end else begin
               for (int e = 0; e < SAVE_DEPTH; e++) begin
                  if (depth_q[c] == DW'(e)) lifo_d[c][e] = cnt_q[c];
               end
               depth_d[c] = depth_q[c] + DW'(1);
            end
         end

         if (bus.clear[c]) begin
            cnt_d[c] = '0;
         end else if (do_rev) begin
            if (depth_q[c] == '0) begin
               err_d[c] = 1'b1;
            end else begin
               for (int e = 0; e < SAVE_DEPTH; e++) begin
                  if (depth_q[c] == DW'(e + 1)) cnt_d[c] = lifo_q[c][e];
               end
               depth_d[c] = depth_q[c] - DW'(1);
            end
         end else if (bus.count_enable[c] && (rval != '0)) begin
            if (!bus.count_down[c]) begin
               // A count above a lowered limit keeps climbing and wraps modulo 2^N.
               if (cnt_q[c] != rval) begin
                  cnt_d[c] = cnt_q[c] + cnt_t'(1);
               end else if (!bus.sat_mode[c]) begin
                  cnt_d[c]  = cnt_t'(1);
                  wrap_d[c] = 1'b1;
               end
            end else begin
               if (cnt_q[c] > cnt_t'(1)) begin
                  cnt_d[c] = cnt_q[c] - cnt_t'(1);
               end else if (!bus.sat_mode[c]) begin
                  cnt_d[c]  = rval;
                  wrap_d[c] = 1'b1;
               end
            end
         end

         flag_d[c]  = ~bus.clear[c] & (rval != '0) &
                      (bus.count_down[c] ? (cnt_d[c] == cnt_t'(1)) : (cnt_d[c] == rval));
         full_d[c]  = (depth_d[c] == DW'(SAVE_DEPTH));
         empty_d[c] = (depth_d[c] == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int c = 0; c < NUM_CH; c++) begin
            cnt_q[c]   <= '0;
            depth_q[c] <= '0;
            for (int e = 0; e < SAVE_DEPTH; e++) lifo_q[c][e] <= '0;
         end
         flag_q  <= '0;
         wrap_q  <= '0;
         full_q  <= '0;
         empty_q <= '1;
         err_q   <= '0;
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            cnt_q[c]   <= cnt_d[c];
            depth_q[c] <= depth_d[c];
            lifo_q[c]  <= lifo_d[c];
         end
         flag_q  <= flag_d;
         wrap_q  <= wrap_d;
         full_q  <= full_d;
         empty_q <= empty_d;
         err_q   <= err_d;
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_out
      assign bus.count_out[g*NUM_CNT_BITS +: NUM_CNT_BITS] = cnt_q[g];
   end
   assign bus.rollover_flag = flag_q;
   assign bus.wrap_pulse    = wrap_q;
   assign bus.save_full     = full_q;
   assign bus.save_empty    = empty_q;
   assign bus.revert_err    = err_q;
endmodule

// File: tb/tb_flex_counter_bank.sv
// Bench for flex_counter_bank: vector table, directed corner sequences and
// randomized traffic scored against a queue-based reference model.
module tb_flex_counter_bank;
   localparam int NUM_CH     = 4;
   localparam int N          = 8;
   localparam int SAVE_DEPTH = 2;
   localparam int OUT_W      = NUM_CH*N + 5*NUM_CH;

   logic clk = 1'b0;
   logic rst_v;
   logic [NUM_CH-1:0]   clear_v, en_v, down_v, sat_v, save_v, rev_v;
   logic [NUM_CH*N-1:0] rval_v;

   int checks   = 0;
   int failures = 0;

   // reference model state
   int m_cnt  [NUM_CH];
   int m_lifo [NUM_CH][$];
   bit m_err  [NUM_CH];
   bit m_flag [NUM_CH];
   bit m_wrap [NUM_CH];
   logic [OUT_W-1:0] exp_q[$];

   flex_counter_bank_if #(.NUM_CH(NUM_CH), .NUM_CNT_BITS(N)) bus ();

   assign bus.clear        = clear_v;
   assign bus.count_enable = en_v;
   assign bus.count_down   = down_v;
   assign bus.sat_mode     = sat_v;
   assign bus.save_count   = save_v;
   assign bus.revert_count = rev_v;
   assign bus.rollover_val = rval_v;

   flex_counter_bank #(.NUM_CH(NUM_CH), .NUM_CNT_BITS(N), .SAVE_DEPTH(SAVE_DEPTH)) dut (
      .clk (clk),
      .rst (rst_v),
      .bus (bus.slave)
   );

   // clock
   always #5 clk = ~clk;

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      logic [NUM_CH*N-1:0] e_cnt;
      logic [NUM_CH-1:0]   e_flag, e_wrap, e_full, e_empty, e_err;
      for (int c = 0; c < NUM_CH; c++) begin
         int r;
         bit eff_rev;
         bit eff_save;
         r = int'(rval_v[c*N +: N]);
         m_wrap[c] = 0;
         if (rst_v) begin
            m_cnt[c] = 0;
            m_lifo[c].delete();
            m_err[c]  = 0;
            m_flag[c] = 0;
         end else begin
            eff_rev  = rev_v[c] && !clear_v[c];
            eff_save = save_v[c] && !eff_rev;
            if (eff_save) begin
               if (m_lifo[c].size() == SAVE_DEPTH) m_err[c] = 1;
               else m_lifo[c].push_back(m_cnt[c]);
            end
            if (clear_v[c]) begin
               m_cnt[c] = 0;
            end else if (eff_rev) begin
               if (m_lifo[c].size() == 0) m_err[c] = 1;
               else m_cnt[c] = m_lifo[c].pop_back();
            end else if (en_v[c] && r != 0) begin
               if (!down_v[c]) begin
                  if (m_cnt[c] == r) begin
                     if (!sat_v[c]) begin m_cnt[c] = 1; m_wrap[c] = 1; end
                  end else begin
                     m_cnt[c] = (m_cnt[c] + 1) % 256;
                  end
               end else if (m_cnt[c] > 1) begin
                  m_cnt[c] = m_cnt[c] - 1;
               end else if (!sat_v[c]) begin
                  m_cnt[c] = r; m_wrap[c] = 1;
               end
            end
            m_flag[c] = !clear_v[c] && r != 0 && (down_v[c] ? (m_cnt[c] == 1) : (m_cnt[c] == r));
         end
         e_cnt[c*N +: N] = N'(m_cnt[c]);
         e_flag[c]  = m_flag[c];
         e_wrap[c]  = m_wrap[c];
         e_full[c]  = (m_lifo[c].size() == SAVE_DEPTH);
         e_empty[c] = (m_lifo[c].size() == 0);
         e_err[c]   = m_err[c];
      end
      exp_q.push_back({e_cnt, e_flag, e_wrap, e_full, e_empty, e_err});
   endtask

   task automatic compare_all();
      logic [OUT_W-1:0] e;
      checks++;
      if (exp_q.size() == 0) begin
         failures++;
         $display("FAIL scoreboard_empty act=0 exp=1");
         return;
      end
      e = exp_q.pop_front();
      chk("count_out",     64'(bus.count_out),     64'(e[OUT_W-1 -: NUM_CH*N]));
      chk("rollover_flag", 64'(bus.rollover_flag), 64'(e[5*NUM_CH-1 -: NUM_CH]));
      chk("wrap_pulse",    64'(bus.wrap_pulse),    64'(e[4*NUM_CH-1 -: NUM_CH]));
      chk("save_full",     64'(bus.save_full),     64'(e[3*NUM_CH-1 -: NUM_CH]));
      chk("save_empty",    64'(bus.save_empty),    64'(e[2*NUM_CH-1 -: NUM_CH]));
      chk("revert_err",    64'(bus.revert_err),    64'(e[NUM_CH-1 -: NUM_CH]));
   endtask

   // one clock: model predicts from the driven inputs, DUT is sampled 1ns after the edge
   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic drive_idle();
      rst_v = 0; clear_v = '0; en_v = '0; down_v = '0; sat_v = '0;
      save_v = '0; rev_v = '0; rval_v = '0;
   endtask

   task automatic drive_ch(int ch, bit clr, bit en, bit dn, bit sat, bit sv, bit rv, logic [N-1:0] rval);
      drive_idle();
      clear_v[ch] = clr; en_v[ch] = en; down_v[ch] = dn; sat_v[ch] = sat;
      save_v[ch] = sv; rev_v[ch] = rv;
      rval_v[ch*N +: N] = rval;
   endtask

   function automatic logic [63:0] cnt_of(int ch);
      return 64'(bus.count_out[ch*N +: N]);
   endfunction

   typedef struct {
      int          ch;
      bit          clr, en, dn, sat;
      logic [N-1:0] rval;
      int          exp_cnt;
      bit          exp_flag, exp_wrap;
   } vec_t;

   vec_t vecs[15];

   initial begin
      // ch0 up/wrap to 5, then ch1 down/sat and down/wrap at rval 3
      vecs[0]  = '{0, 1, 0, 0, 0, 8'd5, 0, 0, 0};
      vecs[1]  = '{0, 0, 1, 0, 0, 8'd5, 1, 0, 0};
      vecs[2]  = '{0, 0, 1, 0, 0, 8'd5, 2, 0, 0};
      vecs[3]  = '{0, 0, 1, 0, 0, 8'd5, 3, 0, 0};
      vecs[4]  = '{0, 0, 1, 0, 0, 8'd5, 4, 0, 0};
      vecs[5]  = '{0, 0, 1, 0, 0, 8'd5, 5, 1, 0};
      vecs[6]  = '{0, 0, 1, 0, 0, 8'd5, 1, 0, 1};
      vecs[7]  = '{0, 0, 1, 0, 0, 8'd5, 2, 0, 0};
      vecs[8]  = '{1, 1, 0, 1, 1, 8'd3, 0, 0, 0};
      vecs[9]  = '{1, 0, 1, 1, 1, 8'd3, 0, 0, 0};
      vecs[10] = '{1, 0, 1, 1, 1, 8'd3, 0, 0, 0};
      vecs[11] = '{1, 0, 1, 1, 1, 8'd3, 0, 0, 0};
      vecs[12] = '{1, 0, 1, 1, 0, 8'd3, 3, 0, 1};
      vecs[13] = '{1, 0, 1, 1, 0, 8'd3, 2, 0, 0};
      vecs[14] = '{1, 0, 1, 1, 0, 8'd3, 1, 1, 0};

      // reset
      drive_idle();
      rst_v = 1;
      cycle();
      chk("reset_count", 64'(bus.count_out), 64'd0);
      chk("reset_empty", 64'(bus.save_empty), 64'hF);
      chk("reset_full",  64'(bus.save_full), 64'd0);
      chk("reset_err",   64'(bus.revert_err), 64'd0);

      // table
      for (int i = 0; i < 15; i++) begin
         drive_ch(vecs[i].ch, vecs[i].clr, vecs[i].en, vecs[i].dn, vecs[i].sat, 0, 0, vecs[i].rval);
         cycle();
         chk($sformatf("vec%0d_cnt", i),  cnt_of(vecs[i].ch), 64'(vecs[i].exp_cnt));
         chk($sformatf("vec%0d_flag", i), 64'(bus.rollover_flag[vecs[i].ch]), 64'(vecs[i].exp_flag));
         chk($sformatf("vec%0d_wrap", i), 64'(bus.wrap_pulse[vecs[i].ch]), 64'(vecs[i].exp_wrap));
      end

      // nested save/revert on ch2
      drive_ch(2, 1, 0, 0, 0, 0, 0, 8'd10); cycle();
      for (int i = 0; i < 4; i++) begin drive_ch(2, 0, 1, 0, 0, 0, 0, 8'd10); cycle(); end
      drive_ch(2, 0, 0, 0, 0, 1, 0, 8'd10); cycle();
      for (int i = 0; i < 3; i++) begin drive_ch(2, 0, 1, 0, 0, 0, 0, 8'd10); cycle(); end
      chk("t3_at7", cnt_of(2), 64'd7);
      drive_ch(2, 0, 0, 0, 0, 1, 0, 8'd10); cycle();
      chk("t3_full", 64'(bus.save_full[2]), 64'd1);
      drive_ch(2, 0, 1, 0, 0, 0, 1, 8'd10); cycle();
      chk("t3_rev7", cnt_of(2), 64'd7);
      drive_ch(2, 0, 0, 0, 0, 0, 1, 8'd10); cycle();
      chk("t3_rev4", cnt_of(2), 64'd4);
      chk("t3_err0", 64'(bus.revert_err[2]), 64'd0);
      drive_ch(2, 0, 1, 0, 0, 0, 1, 8'd10); cycle();
      chk("t3_hold4", cnt_of(2), 64'd4);
      chk("t3_err1", 64'(bus.revert_err[2]), 64'd1);

      // ch3 overfill
      drive_ch(3, 1, 0, 0, 0, 0, 0, 8'd20); cycle();
      drive_ch(3, 0, 1, 0, 0, 0, 0, 8'd20); cycle();
      drive_ch(3, 0, 1, 0, 0, 1, 0, 8'd20); cycle();
      chk("t4_full_after1", 64'(bus.save_full[3]), 64'd0);
      drive_ch(3, 0, 1, 0, 0, 1, 0, 8'd20); cycle();
      chk("t4_full_after2", 64'(bus.save_full[3]), 64'd1);
      chk("t4_err_after2", 64'(bus.revert_err[3]), 64'd0);
      drive_ch(3, 0, 1, 0, 0, 1, 0, 8'd20); cycle();
      chk("t4_err_after3", 64'(bus.revert_err[3]), 64'd1);
      chk("t4_cnt4", cnt_of(3), 64'd4);
      drive_ch(3, 0, 0, 0, 0, 0, 1, 8'd20); cycle();
      chk("t4_pop2", cnt_of(3), 64'd2);
      drive_ch(3, 0, 0, 0, 0, 0, 1, 8'd20); cycle();
      chk("t4_pop1", cnt_of(3), 64'd1);
      chk("t4_empty", 64'(bus.save_empty[3]), 64'd1);

      // clear beats revert and enable on ch0
      drive_ch(0, 1, 0, 0, 0, 0, 0, 8'd5); cycle();
      for (int i = 0; i < 3; i++) begin drive_ch(0, 0, 1, 0, 0, 0, 0, 8'd5); cycle(); end
      drive_ch(0, 0, 0, 0, 0, 1, 0, 8'd5); cycle();
      drive_ch(0, 1, 1, 0, 0, 0, 1, 8'd5); cycle();
      chk("t5_cleared", cnt_of(0), 64'd0);
      chk("t5_depth_kept", 64'(bus.save_empty[0]), 64'd0);
      drive_ch(0, 0, 0, 0, 0, 0, 1, 8'd5); cycle();
      chk("t5_pop3", cnt_of(0), 64'd3);

      // reset with everything busy
      drive_idle(); clear_v = '1; rval_v = {NUM_CH{8'd9}}; cycle();
      drive_idle(); en_v = '1; save_v = '1; rval_v = {NUM_CH{8'd9}}; cycle(); cycle();
      chk("t6_full", 64'(bus.save_full), 64'hF);
      rst_v = 1; clear_v = '1; rev_v = '1; cycle();
      chk("t6_count", 64'(bus.count_out), 64'd0);
      chk("t6_empty", 64'(bus.save_empty), 64'hF);
      chk("t6_full0", 64'(bus.save_full), 64'd0);
      chk("t6_err", 64'(bus.revert_err), 64'd0);
      chk("t6_flag", 64'(bus.rollover_flag), 64'd0);
      chk("t6_wrap", 64'(bus.wrap_pulse), 64'd0);

      // randomized traffic
      drive_idle();
      for (int c = 0; c < NUM_CH; c++) rval_v[c*N +: N] = N'($urandom_range(1, 6));
      for (int i = 0; i < 1500; i++) begin
         rst_v = ($urandom_range(0, 99) == 0);
         for (int c = 0; c < NUM_CH; c++) begin
            clear_v[c] = ($urandom_range(0, 15) == 0);
            en_v[c]    = ($urandom_range(0, 3) != 0);
            down_v[c]  = $urandom_range(0, 1);
            sat_v[c]   = $urandom_range(0, 1);
            save_v[c]  = ($urandom_range(0, 5) == 0);
            rev_v[c]   = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 19) == 0) begin
               case ($urandom_range(0, 3))
                  0:       rval_v[c*N +: N] = '0;
                  1:       rval_v[c*N +: N] = N'($urandom_range(0, 255));
                  default: rval_v[c*N +: N] = N'($urandom_range(1, 6));
               endcase
            end
         end
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
